hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 48 ++++
 rtl/div_stall_ctrl.sv | 67 ++++++
 rtl/hazard_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-hazard definitions: operand-forward selects and divider FSM states.
package hazard_unit_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 6;

    // Forward-select encoding seen by the datapath operand muxes
    typedef enum logic [FWD_W-1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // Divider occupancy states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Writeback stage tag used for forward matching
    typedef struct packed {
        logic [REG_W-1:0] writereg;
        logic             regwrite;
    } wb_tag_t;

    // E-stage operand select: a write in M is newer than one in W, so M wins
    function automatic fwd_sel_e fwd_select(input logic [REG_W-1:0] src,
                                            input wb_tag_t          mem,
                                            input wb_tag_t          wb);
        fwd_sel_e sel;
        sel = FWD_NONE;
        if ((src != '0) && (src == mem.writereg) && mem.regwrite) begin
            sel = FWD_MEM;
        end else if ((src != '0) && (src == wb.writereg) && wb.regwrite) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // D-stage branch operand select: only the M-stage ALU result is reachable
    function automatic logic fwd_branch(input logic [REG_W-1:0] src,
                                        input wb_tag_t          mem);
        return (src != '0) && (src == mem.writereg) && mem.regwrite;
    endfunction

endpackage

// File: rtl/div_stall_ctrl.sv
// Divider occupancy tracker: holds E for DIV_CYCLES cycles, then flags the result.
module div_stall_ctrl
    import hazard_unit_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic divstartE,
    output logic divstall,
    output logic divdoneE
);

    // First stall cycle is spent in IDLE, last one at count zero in BUSY
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 2);

    div_state_e       state_q;
    div_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and counter registers, reset aborts any running division
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and stall/done decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        divstall = 1'b0;
        divdoneE = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (divstartE) begin
                    divstall = 1'b1;
                    state_d  = DIV_BUSY;
                    cnt_d    = LOAD_VAL;
                end
            end
            DIV_BUSY: begin
                divstall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_DONE: begin
                // Result cycle; a divstartE seen here belongs to the instruction leaving E
                divdoneE = 1'b1;
                state_d  = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding plus load-use, branch and divider stalls.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic             branchD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic             regwriteM,
    input  logic             memtoregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteW,
    input  logic             divstartE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [FWD_W-1:0] forwardaE,
    output logic [FWD_W-1:0] forwardbE,
    output logic             divbusy,
    output logic             divdoneE
);

    wb_tag_t mem_tag;
    wb_tag_t wb_tag;
    logic    lwstall;
    logic    branchstall;
    logic    divstall;

    div_stall_ctrl #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_stall_ctrl (
        .clk       (clk),
        .rst       (rst),
        .divstartE (divstartE),
        .divstall  (divstall),
        .divdoneE  (divdoneE)
    );

    // Group destination tags of the stages that can supply forwarded data
    always_comb begin
        mem_tag = '{writereg: writeregM, regwrite: regwriteM};
        wb_tag  = '{writereg: writeregW, regwrite: regwriteW};
    end

    // Forward selects for E-stage ALU operands and D-stage branch compare
    always_comb begin
        forwardaE = fwd_select(rsE, mem_tag, wb_tag);
        forwardbE = fwd_select(rtE, mem_tag, wb_tag);
        forwardaD = fwd_branch(rsD, mem_tag);
        forwardbD = fwd_branch(rtD, mem_tag);
    end

    // Load-use and branch-operand hazard detection
    always_comb begin
        lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
        branchstall = branchD &
                      ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                       (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    end

    // Pipeline controls; a divider-held E stage must keep its instruction
    always_comb begin
        stallF  = lwstall | branchstall | divstall;
        stallD  = lwstall | branchstall | divstall;
        stallE  = divstall;
        flushE  = (lwstall | branchstall) & ~divstall;
        divbusy = divstall;
    end

endmodule
